// File: rtl/sprite_rle_loader.sv
`default_nettype none
// ============================================================================
// Module : sprite_rle_loader
// Desc   : Expands a run-length-encoded sprite byte stream into one
//          palette-index RAM write per clock.
// Rev    : 1.0  initial release
// ============================================================================
module sprite_rle_loader #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned PIX_W        = 5,
  parameter int unsigned PALETTE_SIZE = 23,
  parameter int unsigned BASE_ADDR    = 0,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] write_address,
  output logic [PIX_W-1:0]  wr_data,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WIDTH  = 3'd1,
    S_HEIGHT = 3'd2,
    S_COUNT  = 3'd3,
    S_INDEX  = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t           r_state;
  logic [7:0]       r_width;
  logic [15:0]      r_total;
  logic [15:0]      r_pix;
  logic [7:0]       r_run;
  logic [PIX_W-1:0] r_idx;

  logic        w_accept;
  logic        w_is_sync;
  logic [15:0] w_pix_next;

  assign w_accept   = in_valid && in_ready;
  assign w_is_sync  = (in_data == SYNC_BYTE);
  assign w_pix_next = r_pix + 16'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_width <= '0;
      r_total <= '0;
      r_pix   <= '0;
      r_run   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_sync) r_state <= S_WIDTH;
        end
        S_WIDTH: begin
          if (w_accept) begin
            if (in_data == 8'd0) begin
              r_state <= S_ERROR;
            end else begin
              r_width <= in_data;
              r_state <= S_HEIGHT;
            end
          end
        end
        S_HEIGHT: begin
          if (w_accept) begin
            if (in_data == 8'd0) begin
              r_state <= S_ERROR;
            end else begin
              // Height is only ever needed through the pixel total.
              r_total <= 16'(r_width) * 16'(in_data);
              r_pix   <= '0;
              r_state <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (w_accept) begin
            if (in_data == 8'd0) begin
              r_state <= S_ERROR;
            end else begin
              r_run   <= in_data;
              r_state <= S_INDEX;
            end
          end
        end
        S_INDEX: begin
          if (w_accept) begin
            if (32'(in_data) >= PALETTE_SIZE) begin
              r_state <= S_ERROR;
            end else begin
              r_idx   <= PIX_W'(in_data);
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_pix <= w_pix_next;
          r_run <= r_run - 8'd1;
          // Overrun beats a normal run end: the frame is full but the run is not.
          if ((w_pix_next == r_total) && (r_run > 8'd1)) begin
            r_state <= S_ERROR;
          end else if (r_run == 8'd1) begin
            r_state <= (w_pix_next == r_total) ? S_DONE : S_COUNT;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_ERROR: begin
          if (w_accept && w_is_sync) r_state <= S_WIDTH;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign we            = (r_state == S_WRITE);
  assign wr_data       = r_idx;
  assign write_address = c_BASE + ADDR_W'(r_pix);
  assign done          = (r_state == S_DONE);
  assign error         = (r_state == S_ERROR);
  assign busy          = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign in_ready      = (r_state != S_WRITE) && (r_state != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sprite_rle_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_sprite_rle_loader
// Desc   : Self-checking bench for sprite_rle_loader against a frame-level
//          reference model, with directed and randomized frames.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sprite_rle_loader;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned PIX_W  = 5;
  localparam int unsigned PAL    = 23;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [15:0] addr;
    logic [4:0]  data;
  } wr_t;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [7:0]        in_data = 8'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] write_address;
  logic [PIX_W-1:0]  wr_data;
  logic              we;
  logic              busy;
  logic              done;
  logic              error;

  sprite_rle_loader #(
    .ADDR_W(ADDR_W), .PIX_W(PIX_W), .PALETTE_SIZE(PAL), .BASE_ADDR(0), .SYNC_BYTE(8'hA5)
  ) u_dut (
    .Clk(Clk), .Reset(Reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .write_address(write_address), .wr_data(wr_data), .we(we), .busy(busy),
    .done(done), .error(error)
  );

  always #5 Clk = ~Clk;

  int  checks = 0;
  int  failures = 0;
  wr_t exp_q[$];
  int  done_cnt = 0;
  int  wr_cnt = 0;
  bit  mon_en = 1'b0;
  time t_sync = 0;
  time t_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin : mon
    wr_t e;
    if (mon_en && !Reset) begin
      if (we) begin
        wr_cnt++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(write_address), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
        end
        check("ready_low_in_write", 32'(in_ready), 32'd0);
      end
      if (done) begin
        done_cnt++;
        t_done = $time;
      end
    end
  end

  // Frame-level reference: outcome 0 = clean done, 1 = error, 2 = incomplete.
  task automatic model(input bq_t b, output int outcome, output int nwr);
    int w, h, t, p, k, c, i, n;
    exp_q.delete();
    nwr = 0;
    p = 0;
    outcome = 2;
    if (b.size() < 2) return;
    w = int'(b[1]);
    if (w == 0) begin outcome = 1; return; end
    if (b.size() < 3) return;
    h = int'(b[2]);
    if (h == 0) begin outcome = 1; return; end
    t = (w * h) % 65536;
    k = 3;
    while (1) begin
      if (k >= b.size()) return;
      c = int'(b[k]);
      if (c == 0) begin outcome = 1; return; end
      if (k + 1 >= b.size()) return;
      i = int'(b[k+1]);
      if (i >= PAL) begin outcome = 1; return; end
      k += 2;
      n = (c < t - p) ? c : t - p;
      for (int j = 0; j < n; j++) exp_q.push_back('{addr: 16'(p + j), data: 5'(i)});
      p += n;
      nwr += n;
      if (c > n) begin outcome = 1; return; end
      if (p == t) begin outcome = 0; return; end
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gaps, input bit first);
    int  n;
    bit  acc;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge Clk);
      #1;
    end
    in_data  = v;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 600) begin
      @(negedge Clk);
      acc = in_ready;
      @(posedge Clk);
      if (acc && first) t_sync = $time;
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 32'(n), 32'd0);
  endtask

  task automatic run_frame(input bq_t b, input bit gaps);
    int outcome, nwr, cyc;
    model(b, outcome, nwr);
    done_cnt = 0;
    wr_cnt   = 0;
    foreach (b[j]) send_byte(b[j], gaps, j == 0);
    in_valid = 1'b0;
    cyc = 0;
    while (!((outcome == 0) ? (done_cnt > 0) : (error === 1'b1)) && cyc < 3000) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    if (cyc >= 3000) check("settle_timeout", 32'(cyc), 32'd0);
    repeat (3) @(posedge Clk);
    #1;
    check("write_count", 32'(wr_cnt), 32'(nwr));
    check("writes_pending", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'(outcome == 0));
    check("error_flag", 32'(error), 32'(outcome == 1));
    check("ready_after", 32'(in_ready), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  function automatic bq_t gen_frame();
    bq_t b;
    int  w, h, t, p, c, kind, nruns, bad;
    int  cs[$];
    int  is[$];
    kind = $urandom_range(0, 9);
    w = $urandom_range(1, 6);
    h = $urandom_range(1, 4);
    if (kind == 0) w = 0;
    if (kind == 1) h = 0;
    b = {8'hA5, 8'(w), 8'(h)};
    t = w * h;
    p = 0;
    while (p < t) begin
      c = $urandom_range(1, (t - p < 8) ? t - p : 8);
      cs.push_back(c);
      is.push_back($urandom_range(0, PAL - 1));
      p += c;
    end
    nruns = cs.size();
    if (nruns == 0) begin
      b.push_back(8'd1);
      b.push_back(8'd1);
      return b;
    end
    bad = $urandom_range(0, nruns - 1);
    if (kind == 2) cs[bad] = 0;
    if (kind == 3) is[bad] = $urandom_range(PAL, 31);
    if (kind == 4) cs[nruns-1] = cs[nruns-1] + $urandom_range(1, 3);
    for (int r = 0; r < nruns; r++) begin
      b.push_back(8'(cs[r]));
      b.push_back(8'(is[r]));
    end
    return b;
  endfunction

  initial begin : stim
    bq_t b;
    #2;
    check("rst_we", 32'(we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_addr", 32'(write_address), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    @(posedge Clk);
    #1;
    Reset  = 1'b0;
    mon_en = 1'b1;

    b = {8'hA5, 8'h02, 8'h02, 8'h04, 8'h07};
    run_frame(b, 1'b0);
    b = {8'hA5, 8'h02, 8'h02, 8'h03, 8'h01, 8'h01, 8'h02};
    run_frame(b, 1'b0);
    // Gap-free: done appears 2 + sum(2 + C) edges after the sync edge.
    check("done_latency", 32'((t_done - t_sync - 5) / 10), 32'd10);
    b = {8'hA5, 8'h04, 8'h01, 8'h02, 8'h17};
    run_frame(b, 1'b0);
    b = {8'hA5, 8'h01, 8'h01, 8'h01, 8'h05};
    run_frame(b, 1'b0);
    b = {8'hA5, 8'h01, 8'h02, 8'h05, 8'h03};
    run_frame(b, 1'b0);
    b = {8'hA5, 8'h00};
    run_frame(b, 1'b0);
    b = {8'hA5, 8'h03, 8'h00};
    run_frame(b, 1'b0);
    b = {8'hA5, 8'h03, 8'h01, 8'h00};
    run_frame(b, 1'b0);
    b = {8'hA5, 8'h03, 8'h02, 8'h04, 8'h09, 8'h02, 8'h0B};
    run_frame(b, 1'b1);

    mon_en = 1'b0;
    b = {8'hA5, 8'h02, 8'h05, 8'h0A, 8'h03};
    foreach (b[j]) send_byte(b[j], 1'b0, j == 0);
    in_valid = 1'b0;
    check("first_write_latency", 32'(we), 32'd1);
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    check("third_write_we", 32'(we), 32'd1);
    check("third_write_addr", 32'(write_address), 32'd2);
    Reset = 1'b1;
    #1;
    check("midrst_we", 32'(we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_addr", 32'(write_address), 32'd0);
    check("midrst_data", 32'(wr_data), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
    mon_en = 1'b1;
    b = {8'h02, 8'h01, 8'h03, 8'h04};
    foreach (b[j]) send_byte(b[j], 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    check("no_write_without_sync", 32'(wr_cnt), 32'd0);
    check("idle_without_sync", 32'(busy), 32'd0);
    b = {8'hA5, 8'h02, 8'h03, 8'h06, 8'h10};
    run_frame(b, 1'b0);

    for (int n = 0; n < 40; n++) begin
      b = gen_frame();
      run_frame(b, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_rle_loader.md
# sprite_rle_loader

Streaming decoder that fills the character/sprite RAM read by the color mapper. It accepts run-length-encoded sprite data as a byte stream with a valid/ready handshake. It expands each run into one palette-index write per clock on the RAM write port (`write_address`, data, `we`). It sits between the host byte source (on-chip processor or flash reader) and `characterRAM`.

## Interface
Parameters:
- ADDR_W, 16, width of RAM write address.
- PIX_W, 5, width of a palette index; must be wide enough to hold PALETTE_SIZE-1.
- PALETTE_SIZE, 23, number of valid palette entries; indices ≥ this value are errors.
- BASE_ADDR, 0, RAM address of the first pixel.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte.
- write_address  out  ADDR_W  RAM write address.
- wr_data  out  PIX_W  palette index to write.
- we  out  1  RAM write enable.
- busy  out  1  high in any state except IDLE and ERROR.
- done  out  1  one-cycle pulse when a frame completes cleanly.
- error  out  1  sticky frame error; cleared when the next SYNC_BYTE is accepted.

## Operation
- A byte transfers when in_valid && in_ready at a rising Clk.
- Frame format: SYNC_BYTE, width W (1..255), height H (1..255), then pairs of count C (1..255) and index I (< PALETTE_SIZE).
- Total pixels T = W*H, computed as a 16-bit unsigned product and registered at the HEIGHT accept.
- Pixel p is written to write_address = BASE_ADDR + p. The address is computed mod 2^ADDR_W.
- States: IDLE, WIDTH, HEIGHT, COUNT, INDEX, WRITE, DONE, ERROR.
- IDLE transitions:
  - SYNC accepted → WIDTH.
  - Any other byte is discarded.
- WIDTH transitions:
  - W=0 → ERROR.
  - Otherwise store W → HEIGHT.
- HEIGHT transitions:
  - H=0 → ERROR.
  - Otherwise store H, clear pixel counter → COUNT.
- COUNT transitions:
  - C=0 → ERROR.
  - Otherwise load run counter → INDEX.
- INDEX transitions:
  - I ≥ PALETTE_SIZE → ERROR.
  - Otherwise latch I → WRITE.
- WRITE behaviour:
  - Each cycle: we=1, wr_data=I, write_address=BASE_ADDR+pixel counter.
  - Each cycle, the pixel counter increments and the run counter decrements.
- WRITE exit conditions, priority order:
  - Pixel counter reaches T while run remaining > 1 (overrun): set error, go to ERROR, write nothing further.
  - Run ends with pixel counter = T: go to DONE.
  - Run ends with pixel counter < T: go to COUNT.
- DONE: done=1 for exactly one cycle → IDLE.
- ERROR: error=1; bytes are discarded until SYNC_BYTE is accepted, which clears error and goes to WIDTH.
- SYNC_BYTE seen in WIDTH/HEIGHT/COUNT/INDEX is treated as data, not as a restart.

## Timing
- Reset values, applied asynchronously while Reset=1:
  - State IDLE.
  - we=0, done=0, error=0, busy=0, in_ready=1.
  - write_address=BASE_ADDR, wr_data=0, all counters 0.
- in_ready:
  - 1 in IDLE, WIDTH, HEIGHT, COUNT, INDEX, ERROR.
  - 0 in WRITE and DONE.
  - Decoded from state only; it does not depend on in_valid.
- we, wr_data, write_address and done are decoded from registered state and counters; there is no combinational path from input to output.
- Latency:
  - Index byte accepted at edge N → first write during cycle N+1.
  - A run of C writes occupies exactly C consecutive cycles.
  - After a mid-frame run, in_ready=1 on the cycle after the last write.
- Final run: its last write occupies cycle M, done=1 in cycle M+1, and IDLE (in_ready=1) in cycle M+2.
- Throughput: 2 accept cycles + C write cycles per run, assuming in_valid is continuously high.
- Error on an input byte: error rises the cycle after the offending byte is accepted.
- Error on overrun: error rises the cycle after the T-th write.
- Reset asserted mid-WRITE: we drops immediately. No partial state survives, and the next frame needs a fresh SYNC_BYTE.

## Test plan
- Single run: stream A5,02,02,04,07 → we high 4 consecutive cycles, addresses 0,1,2,3, wr_data=7; done pulses once; error=0.
- Multiple runs: A5,02,02,03,01,01,02 → addresses 0–2 with data 1, address 3 with data 2, then done. Also hold in_valid high throughout and check in_ready=0 during writes and no byte is lost.
- Bad index: A5,04,01,02,17 (index 23) → no write, error=1, in_ready stays 1. A following A5,01,01,01,05 clears error and writes address 0 data 5, then done.
- Overrun: A5,01,02,05,03 → exactly 2 writes (addresses 0,1, data 3), then error=1 and no done pulse.
- Zero fields and gaps: W=0, H=0 and C=0 each → error with no write. Separately, toggle in_valid randomly during headers → identical write sequence to the gap-free case.
- Reset mid-run: assert Reset during the 3rd write of C=10 → we=0 in the same cycle and all outputs return to reset values. A frame sent after release completes normally.
